register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 No parameters; widths come from shared defines: REG_BIT=5, ROB_BIT=4, DAT_W=32; 32 architectural registers.
REQ-002 clk  in  1  single clock, all state updates on posedge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 en  in  1  global enable; when low, all state holds.
REQ-005 is_en_i  in  1  issue of a new instruction this cycle.
REQ-006 is_wr_i  in  1  issued instruction writes rd.
REQ-007 is_rd_i, is_rs1_i, is_rs2_i  in  REG_BIT each  dest/source register indices.
REQ-008 rob_qd_i  in  ROB_BIT  ROB tag allocated to the issuing instruction (ROB tail).
REQ-009 qj_o, qk_o  out  ROB_BIT  pending producer tag for rs1/rs2; 0 = operand valid.
REQ-010 vj_o, vk_o  out  DAT_W  operand value for rs1/rs2 when q = 0, else 0.
REQ-011 rob_reqqj_o, rob_reqqk_o  out  ROB_BIT  tag of rs1/rs2 sent to ROB for readiness query.
REQ-012 rob_rdyj_i, rob_rdyk_i  in  1  queried ROB entry is ready.
REQ-013 rob_rdyvj_i, rob_rdyvk_i  in  DAT_W  value of queried ROB entry.
REQ-014 cmt_en_i  in  1  ROB commit writes a register this cycle.
REQ-015 cmt_rd_i  in  REG_BIT; cmt_q_i  in  ROB_BIT; cmt_v_i  in  DAT_W  committed rd, tag, value.
REQ-016 br_flag_i  in  1  misprediction flush.

Function
REQ-017 Storage: val[0..31] (DAT_W), tag[0..31] (ROB_BIT); tag 0 means no pending producer; ROB tags in use are 1..15.
REQ-018 Register x0 reads value 0, tag 0 always; writes and renames to x0 are ignored.
REQ-019 Lookup is combinational, same cycle as issue; per source s: rob_reqq = tag[s].
REQ-020 Lookup priority per source: tag[s]==0 -> (val[s], q=0); else commit bypass hit -> (cmt_v_i, q=0); else ROB ready -> (rob_rdyv, q=0); else (0, q=tag[s]).
REQ-021 Commit bypass hit: cmt_en_i && cmt_rd_i==s && cmt_q_i==tag[s] && s!=0.
REQ-022 Lookup uses pre-update state; a rename by the same issuing instruction never affects its own sources (rd==rs1 reads old producer).
REQ-023 Commit (cmt_en_i, cmt_rd_i!=0): val[cmt_rd_i] <= cmt_v_i, 1-cycle latency.
REQ-024 Commit clears tag[cmt_rd_i] to 0 only if tag[cmt_rd_i]==cmt_q_i; otherwise a newer producer owns rd and the tag is kept.
REQ-025 Issue (is_en_i && is_wr_i && is_rd_i!=0 && !br_flag_i): tag[is_rd_i] <= rob_qd_i.
REQ-026 Same-cycle issue and commit to same rd: value written, tag takes rob_qd_i (rename wins over clear).
REQ-027 Flush (br_flag_i): all tags <= 0 next cycle; values retained; commit in the flush cycle still writes its value; issue in the flush cycle is dropped.
REQ-028 en low: no state change, including flush and commit; lookup outputs remain valid combinationally.

Reset
REQ-029 rst (sync, priority over en and br_flag_i): all val <= 0, all tag <= 0.
REQ-030 After reset every lookup returns (0, q=0) until a commit writes a value; reset mid-operation discards all pending tags.

Configuration
REQ-031 Macro RF_BYPASS_EN: when defined, commit bypass of REQ-020/021 is present.
REQ-032 Without RF_BYPASS_EN: bypass term removed; priority is tag==0 -> ROB ready -> pending; functionally correct since committed entries remain ready in ROB that cycle.

Verification
REQ-033 Reset, commit x5=0x1234 tag 3 (tag[5]=0) -> next cycle rs1=5 gives vj=0x1234, qj=0.
REQ-034 Issue rd=7 tag 4; next cycle rs1=7 with rob_rdyj=0 -> qj=4, vj=0; with rob_rdyj=1, rob_rdyvj=0xAA -> qj=0, vj=0xAA.
REQ-035 tag[7]=4; issue rd=7 tag 6 while committing x7 tag 4 value 0x11 -> val[7]=0x11, tag[7]=6; later commit tag 6 value 0x22 -> tag 0, val 0x22.
REQ-036 tag[9]=2, commit x9 tag 2 value 0x55 same cycle as lookup rs2=9 -> vk=0x55, qk=0 (bypass on); qk=0 via ROB ready path (bypass off).
REQ-037 Tags on x1,x2,x3; br_flag_i with issue rd=4 tag 8 -> next cycle all tags 0, tag[4]=0, values unchanged.
REQ-038 Issue rd=0 tag 5, commit x0 value 0xFF -> rs1=0 reads vj=0, qj=0.

Source files
------------

// File: rtl/register_file.sv
// register_file: architectural register file with rename tags for an
// out-of-order core. Each register holds a committed value plus the ROB tag of
// its newest in-flight producer (tag 0 = value is current).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en                       global enable; when low all state holds
//   is_en_i, is_wr_i         issue strobe, issued instruction writes rd
//   is_rd_i/is_rs1_i/is_rs2_i dest/source register indices
//   rob_qd_i                 ROB tag allocated to the issuing instruction
//   qj_o/qk_o, vj_o/vk_o     operand tag (0 = valid) and value for rs1/rs2
//   rob_reqqj_o/rob_reqqk_o  producer tags sent to the ROB for readiness query
//   rob_rdy*_i, rob_rdyv*_i  ROB query answer (ready flag, value)
//   cmt_en_i, cmt_rd_i, cmt_q_i, cmt_v_i  commit port
//   br_flag_i                misprediction flush (drops all tags)
//
// Configuration: define RF_BYPASS_EN to forward the commit value to a source
// whose pending producer is committing this cycle. Without it the ROB ready
// path covers the same case, since the committing entry is still ready.

`ifndef REG_BIT
`define REG_BIT 5
`endif
`ifndef ROB_BIT
`define ROB_BIT 4
`endif
`ifndef DAT_W
`define DAT_W 32
`endif

module register_file (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                is_en_i,
    input  logic                is_wr_i,
    input  logic [`REG_BIT-1:0] is_rd_i,
    input  logic [`REG_BIT-1:0] is_rs1_i,
    input  logic [`REG_BIT-1:0] is_rs2_i,
    input  logic [`ROB_BIT-1:0] rob_qd_i,
    output logic [`ROB_BIT-1:0] qj_o,
    output logic [`ROB_BIT-1:0] qk_o,
    output logic [`DAT_W-1:0]   vj_o,
    output logic [`DAT_W-1:0]   vk_o,
    output logic [`ROB_BIT-1:0] rob_reqqj_o,
    output logic [`ROB_BIT-1:0] rob_reqqk_o,
    input  logic                rob_rdyj_i,
    input  logic                rob_rdyk_i,
    input  logic [`DAT_W-1:0]   rob_rdyvj_i,
    input  logic [`DAT_W-1:0]   rob_rdyvk_i,
    input  logic                cmt_en_i,
    input  logic [`REG_BIT-1:0] cmt_rd_i,
    input  logic [`ROB_BIT-1:0] cmt_q_i,
    input  logic [`DAT_W-1:0]   cmt_v_i,
    input  logic                br_flag_i
);

    localparam int unsigned NumRegs = 32;

    // Entry 0 is never written, so x0 stays (0, tag 0) from reset onward.
    logic [`DAT_W-1:0]   val_q [NumRegs];
    logic [`ROB_BIT-1:0] tag_q [NumRegs];

    logic [`ROB_BIT-1:0] tag_j, tag_k;

    assign tag_j       = tag_q[is_rs1_i];
    assign tag_k       = tag_q[is_rs2_i];
    assign rob_reqqj_o = tag_j;
    assign rob_reqqk_o = tag_k;

    // Source rs1 lookup on pre-update state.
    always_comb begin
        qj_o = '0;
        vj_o = '0;
        if (tag_j == '0) begin
            vj_o = val_q[is_rs1_i];
`ifdef RF_BYPASS_EN
        end else if (cmt_en_i && cmt_rd_i == is_rs1_i && cmt_q_i == tag_j &&
                     is_rs1_i != '0) begin
            vj_o = cmt_v_i;
`endif
        end else if (rob_rdyj_i) begin
            vj_o = rob_rdyvj_i;
        end else begin
            qj_o = tag_j;
        end
    end

    // Source rs2 lookup on pre-update state.
    always_comb begin
        qk_o = '0;
        vk_o = '0;
        if (tag_k == '0) begin
            vk_o = val_q[is_rs2_i];
`ifdef RF_BYPASS_EN
        end else if (cmt_en_i && cmt_rd_i == is_rs2_i && cmt_q_i == tag_k &&
                     is_rs2_i != '0) begin
            vk_o = cmt_v_i;
`endif
        end else if (rob_rdyk_i) begin
            vk_o = rob_rdyvk_i;
        end else begin
            qk_o = tag_k;
        end
    end

    // Update order matters: commit clear, then flush clear, then rename, so a
    // same-cycle rename overrides the commit clear and a flush drops the rename.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (en) begin
            if (cmt_en_i && cmt_rd_i != '0) begin
                val_q[cmt_rd_i] <= cmt_v_i;
                // Keep the tag if a newer producer has already renamed rd.
                if (tag_q[cmt_rd_i] == cmt_q_i) begin
                    tag_q[cmt_rd_i] <= '0;
                end
            end
            if (br_flag_i) begin
                for (int i = 0; i < NumRegs; i++) begin
                    tag_q[i] <= '0;
                end
            end else if (is_en_i && is_wr_i && is_rd_i != '0) begin
                tag_q[is_rd_i] <= rob_qd_i;
            end
        end
    end

endmodule
